// File: rtl/reg_bus_pkg.sv
// Shared types and helpers for the register-bus splitter fabric.
// Holds the FSM encoding, the default error read pattern and select-field sizing.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    function automatic int sel_width(input int msb, input int lsb);
        return msb - lsb + 1;
    endfunction

endpackage

// File: rtl/reg_bus_splitter_if.sv
// Register bus seen by the splitter: the master-facing request/response
// signals plus the shared slave-facing bus with per-slave select, ack and data.
interface reg_bus_splitter_if #(
    parameter int NUM_SLV = 5,
    parameter int AW      = 9
);
    logic                   reg_cs;
    logic                   reg_wr;
    logic [AW-1:0]          reg_addr;
    logic [31:0]            reg_wdata;
    logic [3:0]             reg_be;
    logic [31:0]            reg_rdata;
    logic                   reg_ack;
    logic                   reg_err;

    logic [NUM_SLV-1:0]     s_cs;
    logic                   s_wr;
    logic [AW-1:0]          s_addr;
    logic [31:0]            s_wdata;
    logic [3:0]             s_be;
    logic [NUM_SLV*32-1:0]  s_rdata;
    logic [NUM_SLV-1:0]     s_ack;

    // Bridge side: issues requests, consumes responses.
    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack, reg_err
    );

    // Fabric side: serves the bridge and drives the peripheral bus.
    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack, reg_err,
        output s_cs, s_wr, s_addr, s_wdata, s_be,
        input  s_rdata, s_ack
    );

endinterface

// File: rtl/reg_bus_tmo_cnt.sv
// Per-access ack watchdog (down-counter loaded at request acceptance) and
// the saturating count of accesses that were abandoned on timeout.
module reg_bus_tmo_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_active,
    input  logic       i_ack,
    output logic       o_expire,
    output logic [7:0] o_tmo_cnt
);

    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] r_cnt;
    logic [7:0]    r_tmo_cnt;

    // An ack landing on the final cycle beats the timeout.
    assign o_expire  = (TIMEOUT != 0) && i_active && !i_ack && (r_cnt == '0);
    assign o_tmo_cnt = r_tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_tmo_cnt <= '0;
        end else begin
            if (i_start) begin
                r_cnt <= LOAD;
            end else if (i_active && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (o_expire && (r_tmo_cnt != 8'hFF)) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_splitter.sv
// Register-bus fabric: decodes an address field to one of NUM_SLV slaves,
// registers request/response, and converts unmapped or hung accesses into errors.
module reg_bus_splitter
    import reg_bus_pkg::*;
#(
    parameter int          NUM_SLV  = 5,
    parameter int          AW       = 9,
    parameter int          SEL_LSB  = 6,
    parameter int          SEL_MSB  = 8,
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic               app_clk,
    input  logic               reset_n,
    reg_bus_splitter_if.slave  bus,
    output logic [7:0]         tmo_cnt
);

    localparam int SW = sel_width(SEL_MSB, SEL_LSB);

    state_t               r_state;
    logic [NUM_SLV-1:0]   r_s_cs;
    logic                 r_s_wr;
    logic [AW-1:0]        r_s_addr;
    logic [31:0]          r_s_wdata;
    logic [3:0]           r_s_be;
    logic [31:0]          r_rdata;
    logic                 r_ack;
    logic                 r_err;

    logic [SW-1:0]        w_idx;
    logic [NUM_SLV-1:0]   w_dec;
    logic                 w_mapped;
    logic                 w_active;
    logic                 w_hit;
    logic                 w_start;
    logic                 w_expire;
    logic [31:0]          w_sel_rdata;

    assign w_idx = bus.reg_addr[SEL_MSB:SEL_LSB];

    // Select decode and read mux are both driven from one-hot vectors, so an
    // out-of-range index simply decodes to no slave.
    always_comb begin
        w_dec       = '0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_dec[i] = (int'(w_idx) == i);
            if (r_s_cs[i]) begin
                w_sel_rdata = w_sel_rdata | bus.s_rdata[32*i +: 32];
            end
        end
    end

    assign w_mapped = |w_dec;
    assign w_active = (r_state == ACCESS);
    assign w_hit    = w_active && |(bus.s_ack & r_s_cs);
    assign w_start  = (r_state == IDLE) && bus.reg_cs && w_mapped;

    reg_bus_tmo_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (app_clk),
        .rst_n     (reset_n),
        .i_start   (w_start),
        .i_active  (w_active),
        .i_ack     (w_hit),
        .o_expire  (w_expire),
        .o_tmo_cnt (tmo_cnt)
    );

    always_ff @(posedge app_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_s_cs    <= '0;
            r_s_wr    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_be    <= '0;
            r_rdata   <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.reg_cs) begin
                        r_s_wr    <= bus.reg_wr;
                        r_s_addr  <= bus.reg_addr;
                        r_s_wdata <= bus.reg_wdata;
                        r_s_be    <= bus.reg_be;
                        if (w_mapped) begin
                            r_s_cs  <= w_dec;
                            r_state <= ACCESS;
                        end else begin
                            r_rdata <= ERR_DATA;
                            r_err   <= 1'b1;
                            r_ack   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                // The master's reg_cs is not looked at here: a started
                // slave access always runs to ack or timeout.
                ACCESS: begin
                    if (w_hit) begin
                        r_s_cs  <= '0;
                        r_rdata <= w_sel_rdata;
                        r_err   <= 1'b0;
                        r_ack   <= 1'b1;
                        r_state <= RESP;
                    end else if (w_expire) begin
                        r_s_cs  <= '0;
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_s_cs  <= '0;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_cs      = r_s_cs;
    assign bus.s_wr      = r_s_wr;
    assign bus.s_addr    = r_s_addr;
    assign bus.s_wdata   = r_s_wdata;
    assign bus.s_be      = r_s_be;
    assign bus.reg_rdata = r_rdata;
    assign bus.reg_ack   = r_ack;
    assign bus.reg_err   = r_err;

endmodule

// File: tb/tb_reg_bus_splitter.sv
// Directed bench for reg_bus_splitter: behavioural slaves with programmable
// ack delay, expected responses queued at issue and checked at reg_ack.
module tb_reg_bus_splitter;
    import reg_bus_pkg::*;

    localparam int NS  = 5;
    localparam int TMO = 16;

    logic       app_clk = 1'b0;
    logic       reset_n;
    logic [7:0] tmo_cnt;

    reg_bus_splitter_if #(.NUM_SLV(NS), .AW(9)) bus ();

    reg_bus_splitter #(
        .NUM_SLV  (NS),
        .AW       (9),
        .SEL_LSB  (6),
        .SEL_MSB  (8),
        .TIMEOUT  (TMO),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .app_clk (app_clk),
        .reset_n (reset_n),
        .bus     (bus),
        .tmo_cnt (tmo_cnt)
    );

    always #5 app_clk = ~app_clk;

    typedef struct packed {
        logic [31:0]   rdata;
        logic          err;
        int            lat;
        logic [NS-1:0] cs;
        int            cs_cycles;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            exp_tmo = 0;
    int            onehot_viol = 0;
    int            dly [NS];
    logic [31:0]   sdata [NS];
    int            scnt [NS] = '{default: 0};
    logic [NS-1:0] mdl_ack = '0;
    logic [NS-1:0] spur = '0;

    for (genvar g = 0; g < NS; g++) begin : g_rd
        assign bus.s_rdata[32*g +: 32] = sdata[g];
    end
    assign bus.s_ack = mdl_ack | spur;

    // Slave i acks dly[i] cycles after its s_cs first appears; dly<0 never acks.
    initial begin
        forever begin
            @(negedge app_clk);
            for (int i = 0; i < NS; i++) begin
                if (bus.s_cs[i]) scnt[i] = scnt[i] + 1;
                else             scnt[i] = 0;
                mdl_ack[i] = (dly[i] >= 0) && (scnt[i] == dly[i] + 1);
            end
            if (!$onehot0(bus.s_cs)) onehot_viol = onehot_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [8:0] addr);
        exp_t e;
        int   idx;
        idx         = int'(addr[8:6]);
        e.cs        = '0;
        e.cs_cycles = 0;
        if (idx >= NS) begin
            e.rdata = 32'hDEAD_BEEF;
            e.err   = 1'b1;
            e.lat   = 1;
        end else begin
            e.cs = NS'(1) << idx;
            if (dly[idx] < 0 || dly[idx] + 1 > TMO) begin
                e.rdata     = 32'hDEAD_BEEF;
                e.err       = 1'b1;
                e.lat       = TMO + 1;
                e.cs_cycles = TMO;
            end else begin
                e.rdata     = sdata[idx];
                e.err       = 1'b0;
                e.lat       = dly[idx] + 2;
                e.cs_cycles = dly[idx] + 1;
            end
        end
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic run_access(input string tag, input logic [8:0] addr, input logic wr,
                              input logic [31:0] wdata, input logic [3:0] be, input int drop_at);
        exp_t e;
        int   lat, csc, bad;
        logic got;
        e = model(addr);
        sb.push_back(e);
        if (e.err && (e.cs != '0) && (exp_tmo < 255)) exp_tmo++;
        bus.reg_addr  = addr;
        bus.reg_wr    = wr;
        bus.reg_wdata = wdata;
        bus.reg_be    = be;
        bus.reg_cs    = 1'b1;
        @(posedge app_clk);
        lat = 0; csc = 0; bad = 0; got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge app_clk);
            lat++;
            if (lat == drop_at) bus.reg_cs = 1'b0;
            if (bus.s_cs != '0) begin
                if (bus.s_cs == e.cs) csc++;
                else                  bad++;
                if (bus.s_addr !== addr || bus.s_wr !== wr ||
                    bus.s_wdata !== wdata || bus.s_be !== be) bad++;
            end
            got = bus.reg_ack;
        end
        bus.reg_cs = 1'b0;
        e = sb.pop_front();
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, lat, e.lat);
        chk({tag, "_rdata"}, bus.reg_rdata, e.rdata);
        chk({tag, "_err"}, 32'(bus.reg_err), 32'(e.err));
        chk({tag, "_scs_cycles"}, csc, e.cs_cycles);
        chk({tag, "_bus_bad"}, bad, 0);
        chk({tag, "_tmo_cnt"}, 32'(tmo_cnt), exp_tmo);
        @(negedge app_clk);
        chk({tag, "_ack_pulse"}, 32'(bus.reg_ack), 32'd0);
    endtask

    initial begin
        int ack_cnt;
        reset_n       = 1'b0;
        bus.reg_cs    = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        bus.reg_be    = '0;
        dly   = '{1, 1, 1, 1, 5};
        sdata = '{32'h0000_00A0, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'hA5A5_0001};
        repeat (3) @(negedge app_clk);
        chk("rst_s_cs", 32'(bus.s_cs), 32'd0);
        chk("rst_reg_ack", 32'(bus.reg_ack), 32'd0);
        chk("rst_reg_err", 32'(bus.reg_err), 32'd0);
        chk("rst_reg_rdata", bus.reg_rdata, 32'd0);
        chk("rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
        reset_n = 1'b1;
        @(negedge app_clk);

        run_access("wr_s2", 9'h084, 1'b1, 32'h1234_5678, 4'hF, 0);
        run_access("rd_s4", 9'h100, 1'b0, 32'h0, 4'hF, 0);
        run_access("unmapped_7", 9'h1C0, 1'b0, 32'h0, 4'hF, 0);
        run_access("unmapped_5", 9'h17F, 1'b1, 32'h5555_AAAA, 4'h2, 0);

        dly[2] = 5;
        run_access("cs_dropped", 9'h088, 1'b0, 32'h0, 4'h3, 2);

        dly[1] = 3;
        fork
            run_access("spur_s1", 9'h040, 1'b0, 32'h0, 4'hF, 0);
            begin
                repeat (2) @(negedge app_clk);
                spur = 5'b01000;
                @(negedge app_clk);
                spur = '0;
            end
        join
        spur    = 5'b01000;
        ack_cnt = 0;
        repeat (3) begin
            @(negedge app_clk);
            if (bus.reg_ack)       ack_cnt++;
            if (bus.s_cs != '0)    ack_cnt++;
        end
        spur = '0;
        chk("idle_spur_ignored", ack_cnt, 0);
        run_access("after_spur_s1", 9'h040, 1'b1, 32'h0BAD_F00D, 4'hC, 0);

        dly[0] = -1;
        run_access("tmo_first", 9'h000, 1'b1, 32'hCAFE_0000, 4'h1, 0);
        chk("tmo_cnt_one", 32'(tmo_cnt), 32'd1);
        for (int k = 0; k < 299; k++) begin
            run_access("tmo_loop", 9'h000, 1'b0, 32'h0, 4'hF, 0);
        end
        chk("tmo_cnt_sat", 32'(tmo_cnt), 32'd255);
        dly[0] = 15;
        run_access("ack_on_tmo_cycle", 9'h000, 1'b0, 32'h0, 4'hF, 0);
        dly[0] = 16;
        run_access("ack_after_tmo", 9'h000, 1'b0, 32'h0, 4'hF, 0);

        dly[2]        = -1;
        bus.reg_addr  = 9'h084;
        bus.reg_wr    = 1'b0;
        bus.reg_wdata = 32'h0;
        bus.reg_be    = 4'hF;
        bus.reg_cs    = 1'b1;
        @(posedge app_clk);
        @(negedge app_clk);
        bus.reg_cs = 1'b0;
        repeat (3) @(negedge app_clk);
        chk("rst_mid_pre_scs", 32'(bus.s_cs), 32'h4);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_s_cs", 32'(bus.s_cs), 32'd0);
        chk("rst_mid_reg_ack", 32'(bus.reg_ack), 32'd0);
        chk("rst_mid_reg_rdata", bus.reg_rdata, 32'd0);
        chk("rst_mid_tmo_cnt", 32'(tmo_cnt), 32'd0);
        ack_cnt = 0;
        repeat (3) begin
            @(negedge app_clk);
            if (bus.reg_ack) ack_cnt++;
        end
        reset_n = 1'b1;
        exp_tmo = 0;
        repeat (20) begin
            @(negedge app_clk);
            if (bus.reg_ack)    ack_cnt++;
            if (bus.s_cs != '0) ack_cnt++;
        end
        chk("rst_mid_no_ack", ack_cnt, 0);
        dly[2] = 1;
        run_access("post_rst_s1", 9'h040, 1'b0, 32'h0, 4'hF, 0);

        chk("scs_onehot0", onehot_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
